// File: rtl/i2s_adc_receiver_pkg.sv
// Shared constants for the WM8731 I2S ADC receiver: FSM encoding, channel codes, default width.
package i2s_adc_receiver_pkg;

  localparam int unsigned DefDataW = 16;

  typedef logic [1:0] rx_state_t;

  localparam rx_state_t StIdle  = 2'd0;
  localparam rx_state_t StAlign = 2'd1;
  localparam rx_state_t StShift = 2'd2;
  localparam rx_state_t StGap   = 2'd3;

  localparam logic ChLeft  = 1'b0;
  localparam logic ChRight = 1'b1;

endpackage

// File: rtl/i2s_adc_receiver_sync_edge.sv
// Multi-stage synchroniser for an asynchronous clock-like input with a one-clk rising-edge strobe.
module i2s_adc_receiver_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/i2s_adc_receiver.sv
// I2S slave receiver for the codec ADC: aligns to LRCK, deserialises 16-bit L/R samples and
// presents each pair on a valid/ready port with sticky overrun and framing-error flags.
module i2s_adc_receiver
  import i2s_adc_receiver_pkg::*;
#(
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_done,
  input  logic              aud_bclk,
  input  logic              aud_adclrck,
  input  logic              aud_adcdat,
  output logic [DATA_W-1:0] out_l,
  output logic [DATA_W-1:0] out_r,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              frame_err,
  output logic              locked
);

  localparam int unsigned CntW = $clog2(DATA_W) + 1;
  localparam logic [CntW-1:0] BitLast = CntW'(DATA_W - 1);

  logic                   bclk_rise;
  logic [SYNC_STAGES-1:0] lrck_sync_q, dat_sync_q;
  logic                   lrck_s, dat_s, lr_edge;

  rx_state_t              state_q, state_d;
  logic                   ch_q, ch_d;
  logic [CntW-1:0]        bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0]      shreg_q, shreg_d;
  logic [DATA_W-1:0]      hold_l_q, hold_l_d;
  logic                   lr_prev_q, lr_prev_d;
  logic                   pub_q, pub_d;
  logic                   ferr_set;

  logic [DATA_W-1:0]      out_l_q, out_r_q;
  logic                   valid_q, overrun_q, frame_err_q;

  i2s_adc_receiver_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bclk_sync (
    .clk  (clk),
    .reset(reset),
    .din  (aud_bclk),
    .rise (bclk_rise)
  );

  // LRCK and DAT go through the same depth as BCLK so they line up with bclk_rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lrck_sync_q <= '0;
      dat_sync_q  <= '0;
    end else begin
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], aud_adclrck};
      dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], aud_adcdat};
    end
  end

  assign lrck_s  = lrck_sync_q[SYNC_STAGES-1];
  assign dat_s   = dat_sync_q[SYNC_STAGES-1];
  assign lr_edge = bclk_rise && (lrck_s != lr_prev_q);

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    hold_l_d  = hold_l_q;
    lr_prev_d = bclk_rise ? lrck_s : lr_prev_q;
    pub_d     = 1'b0;
    ferr_set  = 1'b0;
    case (state_q)
      StIdle: begin
        if (init_done) state_d = StAlign;
      end
      StAlign: begin
        // The left-channel edge is the I2S delay slot, so its DAT bit is dropped.
        if (lr_edge && lrck_s == ChLeft) begin
          state_d  = StShift;
          bitcnt_d = '0;
          ch_d     = ChLeft;
        end
      end
      StShift: begin
        if (lr_edge) begin
          ferr_set = 1'b1;
          state_d  = StAlign;
        end else if (bclk_rise) begin
          shreg_d  = {shreg_q[DATA_W-2:0], dat_s};
          bitcnt_d = bitcnt_q + CntW'(1);
          if (bitcnt_q == BitLast) begin
            state_d = StGap;
            if (ch_q == ChLeft) hold_l_d = shreg_d;
            else                pub_d    = 1'b1;
          end
        end
      end
      default: begin
        if (lr_edge) begin
          if (lrck_s == ChRight && ch_q == ChLeft) begin
            state_d  = StShift;
            ch_d     = ChRight;
            bitcnt_d = '0;
          end else if (lrck_s == ChLeft && ch_q == ChRight) begin
            state_d  = StShift;
            ch_d     = ChLeft;
            bitcnt_d = '0;
          end else begin
            ferr_set = 1'b1;
            state_d  = StAlign;
          end
        end
      end
    endcase
    if (!init_done) begin
      state_d  = StIdle;
      pub_d    = 1'b0;
      ferr_set = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      ch_q      <= ChLeft;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      hold_l_q  <= '0;
      lr_prev_q <= 1'b0;
      pub_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      hold_l_q  <= hold_l_d;
      lr_prev_q <= lr_prev_d;
      pub_q     <= pub_d;
    end
  end

  // Output stage: a publish in the same clk as acceptance keeps out_valid high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_l_q     <= '0;
      out_r_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else if (!init_done) begin
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (ferr_set) frame_err_q <= 1'b1;
      if (pub_q) begin
        out_l_q <= hold_l_q;
        out_r_q <= shreg_q;
        valid_q <= 1'b1;
        if (valid_q && !out_ready) overrun_q <= 1'b1;
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_l     = out_l_q;
  assign out_r     = out_r_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign locked    = (state_q == StShift) || (state_q == StGap);

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Self-checking bench: codec I2S master BFM plus a frame-level model of published pairs and flags.
module tb_i2s_adc_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        init_done = 1'b0;
  logic        aud_bclk = 1'b0;
  logic        aud_adclrck = 1'b1;
  logic        aud_adcdat = 1'b0;
  logic [15:0] out_l, out_r;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        overrun, frame_err, locked;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic valid_prev = 1'b0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  // Model of the output port at frame granularity
  logic        m_valid = 1'b0;
  logic [31:0] m_pair = '0;
  logic        m_overrun = 1'b0;
  logic        m_ferr = 1'b0;

  i2s_adc_receiver dut (
    .clk        (clk),
    .reset      (reset),
    .init_done  (init_done),
    .aud_bclk   (aud_bclk),
    .aud_adclrck(aud_adclrck),
    .aud_adcdat (aud_adcdat),
    .out_l      (out_l),
    .out_r      (out_r),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready) got_q.push_back({out_l, out_r});
    if (out_valid === 1'b1 && !valid_prev) pulses++;
    valid_prev = (out_valid === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_pairs(input string tag);
    repeat (4) @(negedge clk);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // One BCLK per slot (clk/8); data changes while BCLK is low. Slot 0 is the delay slot.
  task automatic send_slots(input logic lr, input logic [15:0] s, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      @(negedge clk);
      aud_bclk    = 1'b0;
      aud_adclrck = lr;
      aud_adcdat  = (k >= 1 && k <= 16) ? s[16-k] : 1'($urandom_range(0, 1));
      repeat (3) @(negedge clk);
      aud_bclk = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic model_pub(input logic [31:0] pair);
    if (out_ready) exp_q.push_back(pair);
    else begin
      if (m_valid) m_overrun = 1'b1;
      m_valid = 1'b1;
      m_pair  = pair;
    end
  endtask

  // Full frame of 32 slots per channel unless the left channel is shortened.
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int lslots);
    send_slots(1'b0, l, 0, lslots - 1);
    send_slots(1'b1, r, 0, 31);
    if (init_done && reset) begin
      if (lslots >= 17) model_pub({l, r});
      else m_ferr = 1'b1;
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #2 out_ready = v;
    if (v && m_valid) begin
      exp_q.push_back(m_pair);
      m_valid = 1'b0;
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_valid"}, out_valid, m_valid);
    check({tag, "_overrun"}, overrun, m_overrun);
    check({tag, "_frame_err"}, frame_err, m_ferr);
  endtask

  initial begin
    logic [15:0] l, r;
    int p0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_out_l", out_l, 16'h0);
    check("rst_out_r", out_r, 16'h0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_locked", locked, 1'b0);
    reset = 1'b1;

    // 1: no capture before init_done, lock on first left edge afterwards
    send_frame(16'($urandom), 16'($urandom), 32);
    check("idle_locked", locked, 1'b0);
    compare_pairs("idle_pairs");
    init_done = 1'b1;
    l = 16'($urandom);
    r = 16'($urandom);
    send_slots(1'b0, l, 0, 31);
    check("lock_after_left", locked, 1'b1);
    send_slots(1'b1, r, 0, 31);
    model_pub({l, r});
    compare_pairs("first_pair");

    // 2: single directed pair, exactly one out_valid pulse
    p0 = pulses;
    send_frame(16'hA55A, 16'h1234, 32);
    compare_pairs("a55a_1234");
    check("one_pulse", pulses - p0, 1);

    for (int i = 0; i < 4; i++) send_frame(16'($urandom), 16'($urandom), 32);
    compare_pairs("random_pairs");
    check_flags("random");

    // 3: consumer stalled across two frames
    set_ready(1'b0);
    send_frame(16'h8000, 16'h0001, 32);
    send_frame(16'h7FFF, 16'hFFFF, 32);
    check("stall_out_l", out_l, 16'h7FFF);
    check("stall_out_r", out_r, 16'hFFFF);
    check_flags("stall");
    set_ready(1'b1);
    @(negedge clk);
    check("accept_valid_hi", out_valid, 1'b1);
    @(negedge clk);
    check("accept_valid_lo", out_valid, 1'b0);
    compare_pairs("stall_pair");

    // 4: short left channel, then a good frame
    send_frame(16'($urandom), 16'($urandom), 11);
    check_flags("short_left");
    send_frame(16'h0F0F, 16'hF0F0, 32);
    compare_pairs("after_short");

    // 5: reset in the middle of the right channel
    send_slots(1'b0, 16'h1357, 0, 31);
    send_slots(1'b1, 16'h2468, 0, 7);
    @(negedge clk);
    reset = 1'b0;
    m_valid = 1'b0;
    m_overrun = 1'b0;
    m_ferr = 1'b0;
    @(negedge clk);
    check("mid_rst_out_l", out_l, 16'h0);
    check("mid_rst_out_r", out_r, 16'h0);
    check("mid_rst_locked", locked, 1'b0);
    check_flags("mid_rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    send_slots(1'b1, 16'h2468, 8, 31);
    compare_pairs("no_partial");
    send_frame(16'($urandom), 16'($urandom), 32);
    compare_pairs("post_reset");

    // 6: init_done drop with a pending pair and both sticky flags set
    set_ready(1'b0);
    send_frame(16'($urandom), 16'($urandom), 32);
    send_frame(16'($urandom), 16'($urandom), 9);
    send_frame(16'($urandom), 16'($urandom), 32);
    check_flags("pre_drop");
    send_slots(1'b0, 16'h9999, 0, 7);
    check("pre_drop_locked", locked, 1'b1);
    init_done = 1'b0;
    m_valid = 1'b0;
    m_overrun = 1'b0;
    m_ferr = 1'b0;
    @(negedge clk);
    check("drop_locked", locked, 1'b0);
    check_flags("drop");
    set_ready(1'b1);
    repeat (2) @(negedge clk);
    init_done = 1'b1;
    send_slots(1'b0, 16'h9999, 8, 31);
    send_slots(1'b1, 16'h6666, 0, 31);
    compare_pairs("no_stale");
    send_frame(16'($urandom), 16'($urandom), 32);
    compare_pairs("after_reinit");
    check_flags("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
